// File: rtl/hilbert_envelope.sv
// Frame-buffered |z|^2 envelope: captures N analytic samples, then streams
// saturated (r^2 + i^2) >> FRAC under valid/ready and reports the frame peak.
module hilbert_envelope #(
  parameter int WIDTH = 21,
  parameter int FRAC  = 10,
  parameter int N     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_in_valid,
  input  logic signed [WIDTH-1:0] i_in_r,
  input  logic signed [WIDTH-1:0] i_in_i,
  output logic                    o_in_ready,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [WIDTH-1:0]        o_out_env,
  output logic                    o_out_last,
  output logic                    o_peak_valid,
  output logic [WIDTH-1:0]        o_peak_env,
  output logic [$clog2(N)-1:0]    o_peak_idx
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {S_CAPTURE, S_LOAD, S_DRAIN, S_PEAK} state_t;

  state_t             r_state, w_state_nxt;
  logic [2*WIDTH-1:0] r_buf [N];
  logic [IW-1:0]      r_wr_idx, r_rd_idx, w_rd_nxt, w_sel;
  logic [WIDTH-1:0]   r_max_env, w_max_env, w_env;
  logic [IW-1:0]      r_max_idx, w_max_idx;
  logic               w_acc, w_hs, w_wr_last, w_rd_last;

  // Squares are taken at 2*WIDTH so -2^(WIDTH-1) squares exactly; the sum
  // gets one extra bit before the shift and saturation.
  function automatic logic [WIDTH-1:0] f_env(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ax, bx, aa, bb;
    logic [2*WIDTH:0]          sum;
    ax  = {{WIDTH{a[WIDTH-1]}}, a};
    bx  = {{WIDTH{b[WIDTH-1]}}, b};
    aa  = ax * ax;
    bb  = bx * bx;
    sum = ({1'b0, aa} + {1'b0, bb}) >> FRAC;
    if (|sum[2*WIDTH:WIDTH]) f_env = '1;
    else                     f_env = sum[WIDTH-1:0];
  endfunction

  assign w_acc     = (r_state == S_CAPTURE) && i_in_valid;
  assign w_hs      = (r_state == S_DRAIN) && o_out_valid && i_out_ready;
  assign w_wr_last = (r_wr_idx == IW'(N-1));
  assign w_rd_last = (r_rd_idx == IW'(N-1));
  assign w_rd_nxt  = r_rd_idx + 1'b1;

  // One squarer pair serves both LOAD (entry 0) and DRAIN (next entry).
  assign w_sel = (r_state == S_DRAIN) ? w_rd_nxt : '0;
  assign w_env = f_env(r_buf[w_sel][2*WIDTH-1:WIDTH], r_buf[w_sel][WIDTH-1:0]);

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    w_max_env = r_max_env;
    w_max_idx = r_max_idx;
    if (o_out_env > r_max_env) begin
      w_max_env = o_out_env;
      w_max_idx = r_rd_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_CAPTURE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    case (r_state)
      S_CAPTURE: begin
        o_in_ready = 1'b1;
        if (w_acc && w_wr_last) w_state_nxt = S_LOAD;
      end
      S_LOAD:  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_hs && w_rd_last) w_state_nxt = S_PEAK;
      S_PEAK:  w_state_nxt = S_CAPTURE;
      default: w_state_nxt = S_CAPTURE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_acc) r_buf[r_wr_idx] <= {i_in_r, i_in_i};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_max_env    <= '0;
      r_max_idx    <= '0;
      o_out_valid  <= 1'b0;
      o_out_env    <= '0;
      o_out_last   <= 1'b0;
      o_peak_valid <= 1'b0;
      o_peak_env   <= '0;
      o_peak_idx   <= '0;
    end else begin
      o_peak_valid <= 1'b0;
      case (r_state)
        S_CAPTURE: begin
          if (i_in_valid) r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
        end
        S_LOAD: begin
          o_out_env   <= w_env;
          o_out_valid <= 1'b1;
          o_out_last  <= 1'b0;
          r_rd_idx    <= '0;
          r_max_env   <= '0;
          r_max_idx   <= '0;
        end
        S_DRAIN: begin
          if (w_hs) begin
            r_max_env <= w_max_env;
            r_max_idx <= w_max_idx;
            if (w_rd_last) begin
              // Final beat: publish the peak so the pulse lands in PEAK.
              o_out_valid  <= 1'b0;
              o_out_last   <= 1'b0;
              o_peak_valid <= 1'b1;
              o_peak_env   <= w_max_env;
              o_peak_idx   <= w_max_idx;
            end else begin
              r_rd_idx   <= w_rd_nxt;
              o_out_env  <= w_env;
              o_out_last <= (w_rd_nxt == IW'(N-1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilbert_envelope.sv
// Bench for hilbert_envelope: queue-based frame model checked every cycle,
// plus directed frames with hand-computed envelope and peak values.
module tb_hilbert_envelope;
  localparam int WIDTH = 21;
  localparam int FRAC  = 10;
  localparam int N     = 8;
  localparam longint SAT = (longint'(1) << WIDTH) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic signed [WIDTH-1:0] in_r = '0;
  logic signed [WIDTH-1:0] in_i = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [WIDTH-1:0]        out_env;
  logic                    out_last;
  logic                    peak_valid;
  logic [WIDTH-1:0]        peak_env;
  logic [$clog2(N)-1:0]    peak_idx;

  hilbert_envelope #(.WIDTH(WIDTH), .FRAC(FRAC), .N(N)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .i_in_r(in_r), .i_in_i(in_i), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_env(out_env),
    .o_out_last(out_last), .o_peak_valid(peak_valid), .o_peak_env(peak_env),
    .o_peak_idx(peak_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic longint env_of(input longint r, input longint i);
    longint s;
    s = (r * r + i * i) >> FRAC;
    return (s > SAT) ? SAT : s;
  endfunction

  // Frame model: samples accumulate until N, then the frame's envelopes queue
  // up behind one idle cycle and the peak appears the cycle after the last beat.
  longint m_cap_r[$], m_cap_i[$], m_exp[$];
  bit     m_load = 1'b0, m_pk = 1'b0;
  longint m_pk_env = 0, m_pk_idx = 0, m_fr_env = 0, m_fr_idx = 0;

  // Observations of the DUT stream for the directed checks.
  int     cyc = 0, hs_cnt = 0, pk_cnt = 0, last_acc = 0, pk_cyc = 0;
  longint got_env[$];
  int     got_last[$], got_cyc[$];
  longint pk_env_seen = 0, pk_idx_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready && !rst) last_acc = cyc;
    if (out_valid && out_ready && !rst) begin
      hs_cnt++;
      got_env.push_back(longint'(out_env));
      got_last.push_back(int'(out_last));
      got_cyc.push_back(cyc);
    end
    if (peak_valid) begin
      pk_cnt++;
      pk_cyc = cyc;
      pk_env_seen = longint'(peak_env);
      pk_idx_seen = longint'(peak_idx);
    end
  end

  always @(negedge clk) begin
    bit e_rdy, e_vld;
    if (chk_on) begin
      e_rdy = (m_exp.size() == 0) && !m_load && !m_pk;
      e_vld = (m_exp.size() != 0) && !m_load;
      chk("in_ready", longint'(in_ready), longint'(e_rdy));
      chk("out_valid", longint'(out_valid), longint'(e_vld));
      chk("peak_valid", longint'(peak_valid), longint'(m_pk));
      chk("peak_env", longint'(peak_env), m_pk_env);
      chk("peak_idx", longint'(peak_idx), m_pk_idx);
      if (e_vld) begin
        chk("out_env", longint'(out_env), m_exp[0]);
        chk("out_last", longint'(out_last), longint'(m_exp.size() == 1));
      end else begin
        chk("out_last_idle", longint'(out_last), 0);
      end
      m_pk = 1'b0;
      if (rst) begin
        m_cap_r.delete(); m_cap_i.delete(); m_exp.delete();
        m_load = 1'b0; m_pk_env = 0; m_pk_idx = 0;
      end else begin
        if (m_load) m_load = 1'b0;
        else if (e_vld && out_ready) begin
          void'(m_exp.pop_front());
          if (m_exp.size() == 0) begin
            m_pk = 1'b1; m_pk_env = m_fr_env; m_pk_idx = m_fr_idx;
          end
        end
        if (e_rdy && in_valid) begin
          m_cap_r.push_back(longint'(in_r));
          m_cap_i.push_back(longint'(in_i));
          if (m_cap_r.size() == N) begin
            m_fr_env = -1;
            for (int k = 0; k < N; k++) begin
              m_exp.push_back(env_of(m_cap_r[k], m_cap_i[k]));
              if (m_exp[k] > m_fr_env) begin m_fr_env = m_exp[k]; m_fr_idx = k; end
            end
            m_cap_r.delete(); m_cap_i.delete();
            m_load = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int r, input int i);
    in_valid = 1'b1; in_r = WIDTH'(r); in_i = WIDTH'(i);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_peak(input int pc0, input string nm);
    int k = 0;
    while (pk_cnt == pc0 && k < 200) begin tick(); k++; end
    chk({nm, "_peak_seen"}, longint'(pk_cnt - pc0), 1);
  endtask

  task automatic chk_frame(input string nm, input int base, input longint lit[N],
                           input longint pe, input longint pi);
    chk({nm, "_beats"}, longint'(got_env.size() - base), N);
    if (got_env.size() - base == N) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("%s_env%0d", nm, k), got_env[base + k], lit[k]);
        chk($sformatf("%s_last%0d", nm, k), longint'(got_last[base + k]), longint'(k == N - 1));
      end
    end
    chk({nm, "_pk_env"}, pk_env_seen, pe);
    chk({nm, "_pk_idx"}, pk_idx_seen, pi);
  endtask

  initial begin
    int base, pc0, h0, stall, k;
    longint lit[N];
    int vr[N], vi[N];

    tick(); chk_on = 1'b1; tick();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_env", longint'(out_env), 0);
    chk("rst_peak_env", longint'(peak_env), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    rst = 1'b0;
    tick();

    // Unit scaling with latency pinned to the last accept.
    base = got_env.size(); pc0 = pk_cnt;
    for (int j = 0; j < N; j++) send(1024, 0);
    wait_peak(pc0, "unit");
    lit = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
    chk_frame("unit", base, lit, 1024, 0);
    if (got_env.size() - base == N) begin
      chk("unit_first_lat", longint'(got_cyc[base] - last_acc), 2);
      chk("unit_last_lat", longint'(got_cyc[base + N - 1] - last_acc), N + 1);
    end
    chk("unit_peak_lat", longint'(pk_cyc - last_acc), N + 2);
    chk("unit_ready_back", longint'(in_ready), 1);

    // Rounding, quadrature, most-negative input and saturation.
    base = got_env.size(); pc0 = pk_cnt;
    vr = '{724, -2048, 0, -1048576, 1448, 1024, 0, 1};
    vi = '{724, 0, -1024, -1048576, 1448, 0, 0, 1};
    for (int j = 0; j < N; j++) send(vr[j], vi[j]);
    wait_peak(pc0, "arith");
    lit = '{1023, 4096, 1024, 2097151, 4095, 1024, 0, 0};
    chk_frame("arith", base, lit, 2097151, 3);

    // Tie on the maximum: earliest index wins.
    base = got_env.size(); pc0 = pk_cnt;
    vr = '{72, 96, 56, 96, 32, 0, 96, 46};
    for (int j = 0; j < N; j++) send(vr[j], 0);
    wait_peak(pc0, "tie");
    lit = '{5, 9, 3, 9, 1, 0, 9, 2};
    chk_frame("tie", base, lit, 9, 1);

    // Backpressure on beat 4 with stray in_valid pulses during drain.
    base = got_env.size(); pc0 = pk_cnt; h0 = hs_cnt; stall = 0; k = 0;
    for (int j = 0; j < N; j++) send(32 * (j + 1), 0);
    while (pk_cnt == pc0 && k < 200) begin
      out_ready = !((hs_cnt - h0 == 3) && stall < 3);
      if (!out_ready) stall++;
      in_valid = k[0]; in_r = WIDTH'(500); in_i = WIDTH'(500);
      tick(); k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_peak_seen", longint'(pk_cnt - pc0), 1);
    chk("bp_stalls", longint'(stall), 3);
    lit = '{1, 4, 9, 16, 25, 36, 49, 64};
    chk_frame("bp", base, lit, 64, 7);

    // Next frame after drain-time pulses starts at index 0.
    base = got_env.size(); pc0 = pk_cnt;
    vr = '{2048, 0, 0, 0, 0, 0, 0, 0};
    for (int j = 0; j < N; j++) send(vr[j], 32);
    wait_peak(pc0, "clean");
    lit = '{4097, 1, 1, 1, 1, 1, 1, 1};
    chk_frame("clean", base, lit, 4097, 0);

    // Reset after five captures, then a fresh frame on the imaginary path.
    base = got_env.size(); pc0 = pk_cnt;
    for (int j = 0; j < 5; j++) send(2048, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int j = 0; j < N; j++) send(0, -32 * (j + 1));
    wait_peak(pc0, "rstcap");
    lit = '{1, 4, 9, 16, 25, 36, 49, 64};
    chk_frame("rstcap", base, lit, 64, 7);

    // Reset while beat 3 is on the output: no peak for the aborted frame.
    pc0 = pk_cnt; h0 = hs_cnt; k = 0;
    for (int j = 0; j < N; j++) send(1024, 1024);
    while (hs_cnt - h0 < 3 && k < 100) begin tick(); k++; end
    chk("rstdr_reach_beat3", longint'(hs_cnt - h0), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstdr_out_valid", longint'(out_valid), 0);
    chk("rstdr_in_ready", longint'(in_ready), 1);
    chk("rstdr_peak_env", longint'(peak_env), 0);
    for (int j = 0; j < 15; j++) tick();
    chk("rstdr_no_peak", longint'(pk_cnt - pc0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
